hack_memory: RTL and testbench
==============================

# hack_memory

Data-memory stage of the HACK CPU. Consumes the CPU's `outM`/`writeM`/`addressM` triple and decodes `address[14:13]` into per-region load strobes, the same split the 4-way demultiplexor performs. Routes writes to data RAM, screen memory or the read-only keyboard register, and returns `inM` to the CPU. Adds a registered screen-write port toward the display controller and a sampled keyboard input.

## Interface
- `DATA_W`, 16, word width
- `RAM_WORDS`, 16384, data RAM depth (0x0000–0x3FFF)
- `SCR_WORDS`, 8192, screen depth (0x4000–0x5FFF)
- `clk  in  1`: sole clock; all state changes on its rising edge
- `reset  in  1`: asynchronous, active-high; clears all registers listed below
- `in  in  16`: write data (CPU `outM`)
- `load  in  1`: write enable (CPU `writeM`)
- `address  in  15`: word address (CPU `addressM`)
- `out  out  16`: read data (CPU `inM`), combinational from `address`
- `kbd_code  in  16`: scan code from keyboard front-end
- `kbd_valid  in  1`: key currently held
- `scr_we  out  1`: one-cycle screen-write strobe
- `scr_addr  out  13`: screen word offset
- `scr_wdata  out  16`: screen write data

## Operation
- Region decode on `address[14:13]`: 00/01 → RAM, 10 → screen, 11 → I/O. In I/O, only `address == 15'h6000` is KBD; 0x6001–0x7FFF are unmapped.
- Write (`load=1`) at rising edge:
  - RAM: `ram[address[13:0]] <= in`.
  - Screen: `scr[address[12:0]] <= in`; also queue a display write.
  - KBD/unmapped: ignored, no state change.
- Read (`out`): combinational.
  - RAM → `ram[address[13:0]]`.
  - Screen → `scr[address[12:0]]` (shadow copy, not the display).
  - KBD → `kbd_reg`.
  - Unmapped → 0.
  - Same-cycle read of a location being written returns the old value; the new value is visible from the next cycle.
- Keyboard: `kbd_reg <= kbd_valid ? kbd_code : 16'h0000` every cycle. A key code therefore appears one cycle after `kbd_valid` rises and reads 0 one cycle after it falls.
- Screen write port: one-stage pipeline.
  - On a screen write, next cycle `scr_we=1`, with `scr_addr`/`scr_wdata` holding the written offset/data.
  - Otherwise `scr_we=0`; `scr_addr`/`scr_wdata` hold their last values.
  - Back-to-back screen writes produce back-to-back strobes with no drops. No backpressure: the display must accept one write per cycle.

## Timing
- Reset values: `kbd_reg=0`, `scr_we=0`, `scr_addr=0`, `scr_wdata=0`.
- RAM and screen shadow are not cleared by reset; contents are undefined until written.
- `out` is 0 for KBD during reset.
- `reset` asserted mid-write: the write in that cycle is not guaranteed to reach RAM/screen, and no `scr_we` strobe is issued for it. `scr_we` is forced 0 asynchronously.
- Latencies:
  - Read: 0 cycles.
  - Write visible to read: 1 cycle.
  - Write to `scr_we`: 1 cycle.
  - `kbd_valid` to `out` (KBD): 1 cycle.
- Address-boundary behaviour:
  - 0x3FFF → RAM; 0x4000 → screen; 0x5FFF → screen; 0x6000 → KBD; 0x6001 → unmapped; 0x7FFF → unmapped.

## Structure
- Shared package/header `hack_defs`:
  - `DATA_W`
  - region codes `REG_RAM_LO=2'b00`, `REG_RAM_HI=2'b01`, `REG_SCR=2'b10`, `REG_IO=2'b11`
  - `KBD_ADDR=15'h6000`
- The CPU and the top-level computer reuse these constants.
- Sub-module `mem_region_decode`:
  - Load fan-out built from the existing 4-way demultiplexor on `address[14:13]`, with the RAM_LO/RAM_HI outputs ORed into one RAM load.
  - Produces `ram_load`, `scr_load`, `kbd_sel`, `unmapped`.
- Storage arrays, the keyboard register and the screen pipeline live in `hack_memory`.

## Test plan
- Reset → `scr_we=0`, `scr_addr=0`, `scr_wdata=0`; read 0x6000 → `out=0`.
- Write 0x1234 @0x0000, then 0xBEEF @0x3FFF → next cycle `out=0x1234` / `0xBEEF` at those addresses. Same-cycle read while writing 0x0000 returns its prior value.
- Write 0xFFFF @0x4000 and 0x0F0F @0x5FFF on consecutive cycles → `scr_we` high 2 consecutive cycles with (`scr_addr`, `scr_wdata`) = (0x0000, 0xFFFF) then (0x1FFF, 0x0F0F). Reads return both values.
- `kbd_valid=1`, `kbd_code=0x0041` for 3 cycles → `out@0x6000=0x0041` from cycle+1. Drop `kbd_valid` → `out=0` one cycle later.
- Write 0xAAAA @0x6000 and @0x7FFF → no RAM/screen change, `scr_we` stays 0. Reads: `out@0x6001=0`, `out@0x6000=kbd_reg`.
- Assert `reset` in the cycle after a screen write → `scr_we` drops immediately, outputs zeroed. RAM data written before reset still reads back.

Source files
------------

// File: rtl/hack_defs_pkg.sv
// hack_defs: shared HACK constants for word width, address regions and the keyboard address
package hack_defs;
  localparam int DATA_W = 16;
  localparam logic [1:0] REG_RAM_LO = 2'b00;
  localparam logic [1:0] REG_RAM_HI = 2'b01;
  localparam logic [1:0] REG_SCR = 2'b10;
  localparam logic [1:0] REG_IO = 2'b11;
  localparam logic [14:0] KBD_ADDR = 15'h6000;
endpackage

// File: rtl/hack_memory_mem_region_decode.sv
// mem_region_decode: 4-way demux of load on address[14:13] plus keyboard/unmapped select
module mem_region_decode
  import hack_defs::*;
(
  input  logic [14:0] address,
  input  logic        load,
  output logic        ram_load,
  output logic        scr_load,
  output logic        kbd_sel,
  output logic        unmapped
);
  logic [3:0] dmux;
  always_comb begin
    dmux = load ? (4'b0001 << address[14:13]) : 4'b0000;
    ram_load = dmux[REG_RAM_LO] | dmux[REG_RAM_HI];
    scr_load = dmux[REG_SCR];
    kbd_sel = address == KBD_ADDR;
    unmapped = address[14:13] == REG_IO && !kbd_sel;
  end
endmodule

// File: rtl/hack_memory.sv
// hack_memory: HACK data memory with RAM, screen shadow, keyboard register and registered screen-write port
module hack_memory
  import hack_defs::*;
#(
  parameter int RAM_WORDS = 16384,
  parameter int SCR_WORDS = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [14:0]       address,
  output logic [DATA_W-1:0] out,
  input  logic [DATA_W-1:0] kbd_code,
  input  logic              kbd_valid,
  output logic              scr_we,
  output logic [12:0]       scr_addr,
  output logic [DATA_W-1:0] scr_wdata
);
  logic ram_load, scr_load, kbd_sel, unmapped;
  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [DATA_W-1:0] scr [SCR_WORDS];
  logic [DATA_W-1:0] kbd_d, kbd_q, scr_wdata_d, scr_wdata_q;
  logic [12:0] scr_addr_d, scr_addr_q;
  logic scr_we_d, scr_we_q;
  mem_region_decode u_dec (
    .address (address),
    .load    (load),
    .ram_load(ram_load),
    .scr_load(scr_load),
    .kbd_sel (kbd_sel),
    .unmapped(unmapped)
  );
  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_load) ram[address[13:0]] <= in;
    if (scr_load) scr[address[12:0]] <= in;
  end
  always_comb begin
    kbd_d = kbd_valid ? kbd_code : '0;
    scr_we_d = scr_load;
    scr_addr_d = scr_load ? address[12:0] : scr_addr_q;
    scr_wdata_d = scr_load ? in : scr_wdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_q <= '0;
      scr_we_q <= 1'b0;
      scr_addr_q <= '0;
      scr_wdata_q <= '0;
    end else begin
      kbd_q <= kbd_d;
      scr_we_q <= scr_we_d;
      scr_addr_q <= scr_addr_d;
      scr_wdata_q <= scr_wdata_d;
    end
  end
  always_comb begin
    out = kbd_sel ? kbd_q : unmapped ? '0 : address[14:13] == REG_SCR ? scr[address[12:0]] : ram[address[13:0]];
    scr_we = scr_we_q;
    scr_addr = scr_addr_q;
    scr_wdata = scr_wdata_q;
  end
endmodule

// File: tb/tb_hack_memory.sv
// tb_hack_memory: scoreboard bench for hack_memory reads, writes, keyboard and screen port
module tb_hack_memory;
  logic clk = 0, reset;
  logic [15:0] in, out, kbd_code, scr_wdata;
  logic load, kbd_valid, scr_we;
  logic [14:0] address;
  logic [12:0] scr_addr;
  int n_chk = 0, n_fail = 0;
  logic [28:0] scr_q [$];
  hack_memory dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .load     (load),
    .address  (address),
    .out      (out),
    .kbd_code (kbd_code),
    .kbd_valid(kbd_valid),
    .scr_we   (scr_we),
    .scr_addr (scr_addr),
    .scr_wdata(scr_wdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (scr_we === 1'b1) begin
      if (scr_q.size() == 0) check("scr_spurious_we", 32'd1, 32'd0);
      else begin
        logic [28:0] e;
        e = scr_q.pop_front();
        check("scr_addr", {19'd0, scr_addr}, {19'd0, e[28:16]});
        check("scr_wdata", {16'd0, scr_wdata}, {16'd0, e[15:0]});
      end
    end
  end
  task automatic wr(input logic [14:0] a, input logic [15:0] d, input bit push = 1);
    address = a;
    in = d;
    load = 1;
    if (push && a[14:13] == 2'b10) scr_q.push_back({a[12:0], d});
    @(posedge clk);
    #1;
    load = 0;
  endtask
  task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(tag, {16'd0, out}, {16'd0, exp});
  endtask
  initial begin
    reset = 1; load = 0; in = 0; address = 0; kbd_code = 0; kbd_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_scr_we", {31'd0, scr_we}, 0);
    check("rst_scr_addr", {19'd0, scr_addr}, 0);
    check("rst_scr_wdata", {16'd0, scr_wdata}, 0);
    rd("rst_kbd_out", 15'h6000, 16'h0000);
    reset = 0;
    @(posedge clk);
    #1;
    wr(15'h0000, 16'h1234);
    wr(15'h3FFF, 16'hBEEF);
    rd("ram_0000", 15'h0000, 16'h1234);
    rd("ram_3fff", 15'h3FFF, 16'hBEEF);
    address = 15'h0000; in = 16'h5555; load = 1;
    #1;
    check("same_cycle_old", {16'd0, out}, 32'h1234);
    @(posedge clk);
    #1;
    load = 0;
    check("write_visible", {16'd0, out}, 32'h5555);
    wr(15'h0000, 16'h1234);
    wr(15'h4000, 16'hFFFF);
    check("scr_we_first", {31'd0, scr_we}, 1);
    wr(15'h5FFF, 16'h0F0F);
    check("scr_we_second", {31'd0, scr_we}, 1);
    @(posedge clk);
    #1;
    check("scr_we_idle", {31'd0, scr_we}, 0);
    check("scr_addr_hold", {19'd0, scr_addr}, 32'h1FFF);
    rd("scr_4000", 15'h4000, 16'hFFFF);
    rd("scr_5fff", 15'h5FFF, 16'h0F0F);
    address = 15'h6000; kbd_code = 16'h0041; kbd_valid = 1;
    #1;
    check("kbd_not_yet", {16'd0, out}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("kbd_held", {16'd0, out}, 32'h0041);
    end
    kbd_valid = 0;
    #1;
    check("kbd_release_lag", {16'd0, out}, 32'h0041);
    @(posedge clk);
    #1;
    check("kbd_released", {16'd0, out}, 0);
    wr(15'h6000, 16'hAAAA);
    check("kbd_wr_no_we", {31'd0, scr_we}, 0);
    wr(15'h7FFF, 16'hAAAA);
    check("unmap_wr_no_we", {31'd0, scr_we}, 0);
    rd("unmap_6001", 15'h6001, 16'h0000);
    rd("unmap_7fff", 15'h7FFF, 16'h0000);
    rd("kbd_after_wr", 15'h6000, 16'h0000);
    rd("scr_alias_0", 15'h4000, 16'hFFFF);
    rd("scr_alias_1fff", 15'h5FFF, 16'h0F0F);
    rd("ram_keep_0", 15'h0000, 16'h1234);
    kbd_code = 16'h1357; kbd_valid = 1;
    @(posedge clk);
    #1;
    rd("kbd_reg_read", 15'h6000, 16'h1357);
    kbd_valid = 0;
    wr(15'h4010, 16'h1111, 0);
    check("pre_rst_we", {31'd0, scr_we}, 1);
    check("pre_rst_addr", {19'd0, scr_addr}, 32'h0010);
    reset = 1;
    #1;
    check("mid_rst_we", {31'd0, scr_we}, 0);
    check("mid_rst_addr", {19'd0, scr_addr}, 0);
    check("mid_rst_wdata", {16'd0, scr_wdata}, 0);
    rd("mid_rst_kbd", 15'h6000, 16'h0000);
    @(posedge clk);
    #1;
    reset = 0;
    rd("post_rst_ram0", 15'h0000, 16'h1234);
    rd("post_rst_ram3fff", 15'h3FFF, 16'hBEEF);
    repeat (2) @(posedge clk);
    #1;
    check("scr_queue_drained", scr_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
